// File: rtl/fio_pkg.sv
// Shared definitions for the dfio word/byte stream stages.
package fio_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned BYTE_W_DEF = 8;

  // Upper bounds for the width-generic helper below; callers zero-extend into these.
  localparam int unsigned MAX_DATA_W = 256;
  localparam int unsigned MAX_BYTE_W = 64;

  function automatic int unsigned nbytes(input int unsigned data_w, input int unsigned byte_w);
    return data_w / byte_w;
  endfunction

  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned NBYTES = nbytes(DATA_W_DEF, BYTE_W_DEF);
  localparam int unsigned IDX_W  = idx_w(NBYTES);

  // Byte lane idx of a word; lsb_first=0 counts lanes from the most significant end.
  function automatic logic [MAX_BYTE_W-1:0] byte_select(
    input logic [MAX_DATA_W-1:0] word,
    input int unsigned           idx,
    input bit                    lsb_first,
    input int unsigned           nb,
    input int unsigned           bw
  );
    int unsigned           sel;
    logic [MAX_DATA_W-1:0] sh;
    logic [MAX_BYTE_W-1:0] mask;
    sel  = lsb_first ? idx : (nb - 1 - idx);
    sh   = word >> (sel * bw);
    mask = (MAX_BYTE_W'(1) << bw) - MAX_BYTE_W'(1);
    return sh[MAX_BYTE_W-1:0] & mask;
  endfunction

endpackage

// File: rtl/word_to_byte_serializer.sv
// Splits dfio words into bytes on a valid/ready stream, with one pending-word slot.
module word_to_byte_serializer
  import fio_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned BYTE_W    = BYTE_W_DEF,
  parameter int unsigned LSB_FIRST = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  word_count
);

  localparam int unsigned NB = nbytes(DATA_W, BYTE_W);
  localparam int unsigned IW = idx_w(NB);

  logic [DATA_W-1:0] act_word;
  logic [DATA_W-1:0] pend_word;
  logic              act_valid;
  logic              pend_valid;
  logic [IW-1:0]     idx;

  logic in_fire;
  logic out_fire;
  logic word_done;

  // Handshake and status decode, all from registered state except the fire terms.
  always_comb begin
    in_ready  = ~pend_valid;
    out_valid = act_valid;
    out_last  = act_valid & (idx == IW'(NB - 1));
    busy      = act_valid | pend_valid;
    in_fire   = in_valid & ~pend_valid;
    out_fire  = act_valid & out_ready;
    word_done = out_fire & out_last;
    out_data  = BYTE_W'(byte_select(MAX_DATA_W'(act_word), 32'(idx), LSB_FIRST != 0, NB, BYTE_W));
  end

  // Active/pending word storage, byte index and completed-word counter.
  // A completing word hands over to pending first, else to a word arriving this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_word   <= '0;
      pend_word  <= '0;
      act_valid  <= 1'b0;
      pend_valid <= 1'b0;
      idx        <= '0;
      word_count <= '0;
    end else begin
      if (out_fire) begin
        if (word_done) begin
          idx        <= '0;
          word_count <= word_count + CNT_W'(1);
          if (pend_valid) begin
            act_word   <= pend_word;
            pend_valid <= 1'b0;
          end else if (in_fire) begin
            act_word <= in_data;
          end else begin
            act_valid <= 1'b0;
          end
        end else begin
          idx <= idx + IW'(1);
        end
      end
      if (in_fire && !word_done) begin
        if (!act_valid) begin
          act_word  <= in_data;
          act_valid <= 1'b1;
          idx       <= '0;
        end else begin
          pend_word  <= in_data;
          pend_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_word_to_byte_serializer.sv
// Bench for word_to_byte_serializer: default, MSB-first and 4-bit-counter builds.
module tb_word_to_byte_serializer;

  logic clk;
  logic rst_n;

  logic        in_valid, in_ready, out_valid, out_last, out_ready, busy;
  logic [31:0] in_data;
  logic [7:0]  out_data;
  logic [15:0] word_count;

  logic        m_in_valid, m_in_ready, m_out_valid, m_out_last, m_out_ready, m_busy;
  logic [31:0] m_in_data;
  logic [7:0]  m_out_data;
  logic [15:0] m_word_count;

  logic        c_in_valid, c_in_ready, c_out_valid, c_out_last, c_out_ready, c_busy;
  logic [31:0] c_in_data;
  logic [7:0]  c_out_data;
  logic [3:0]  c_word_count;

  int checks;
  int errors;
  int pops;

  typedef struct {
    logic [7:0] d;
    logic       l;
  } exp_t;
  exp_t q[$];

  word_to_byte_serializer dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .busy(busy), .word_count(word_count)
  );

  word_to_byte_serializer #(.LSB_FIRST(0)) dut_msb (
    .clk(clk), .rst_n(rst_n),
    .in_valid(m_in_valid), .in_data(m_in_data), .in_ready(m_in_ready),
    .out_valid(m_out_valid), .out_data(m_out_data), .out_last(m_out_last), .out_ready(m_out_ready),
    .busy(m_busy), .word_count(m_word_count)
  );

  word_to_byte_serializer #(.CNT_W(4)) dut_cnt4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(c_in_valid), .in_data(c_in_data), .in_ready(c_in_ready),
    .out_valid(c_out_valid), .out_data(c_out_data), .out_last(c_out_last), .out_ready(c_out_ready),
    .busy(c_busy), .word_count(c_word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic sb_sample();
    exp_t e;
    if (in_valid && in_ready) begin
      for (int b = 0; b < 4; b++) begin
        e.d = 8'((in_data >> (8 * b)) & 32'hFF);
        e.l = (b == 3);
        q.push_back(e);
      end
    end
    if (out_valid && out_ready) begin
      pops++;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got byte %02h, required no byte", out_data);
      end else begin
        e = q.pop_front();
        if (out_data !== e.d || out_last !== e.l) begin
          errors++;
          $display("FAIL sb_byte: got %02h last %0b, required %02h last %0b", out_data, out_last, e.d, e.l);
        end
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    sb_sample();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_data = '0; out_ready = 1;
    m_in_valid = 0; m_in_data = '0; m_out_ready = 1;
    c_in_valid = 0; c_in_data = '0; c_out_ready = 1;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge clk);
    rst_n = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (out_valid !== 0 || out_last !== 0 || busy !== 0 || in_ready !== 1 || out_data !== 8'h00 || word_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: got v%0b l%0b b%0b r%0b d%02h wc%0d, required v0 l0 b0 r1 d00 wc0",
               out_valid, out_last, busy, in_ready, out_data, word_count);
    end
    checks++;
    if (m_out_valid !== 0 || c_out_valid !== 0 || c_word_count !== 4'd0) begin
      errors++;
      $display("FAIL reset_variants: got m_v%0b c_v%0b c_wc%0d, required 0 0 0", m_out_valid, c_out_valid, c_word_count);
    end
  endtask

  task automatic test_single();
    do_reset();
    in_valid = 1; in_data = 32'hA1B2C3D4;
    cycle();
    in_valid = 0; in_data = 'x;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1) begin
        errors++;
        $display("FAIL single_valid[%0d]: got %0b, required 1", i, out_valid);
      end
      cycle();
    end
    in_data = '0;
    checks++;
    if (busy !== 0 || out_valid !== 0 || word_count !== 16'd1) begin
      errors++;
      $display("FAIL single_end: got busy %0b v %0b wc %0d, required 0 0 1", busy, out_valid, word_count);
    end
  endtask

  task automatic test_msb();
    logic [7:0] exp_b [4];
    exp_b[0] = 8'hA1; exp_b[1] = 8'hB2; exp_b[2] = 8'hC3; exp_b[3] = 8'hD4;
    do_reset();
    m_in_valid = 1; m_in_data = 32'hA1B2C3D4;
    cycle();
    m_in_valid = 0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (m_out_valid !== 1 || m_out_data !== exp_b[i] || m_out_last !== (i == 3)) begin
        errors++;
        $display("FAIL msb_byte[%0d]: got v%0b %02h last %0b, required v1 %02h last %0b",
                 i, m_out_valid, m_out_data, m_out_last, exp_b[i], (i == 3));
      end
      cycle();
    end
    checks++;
    if (m_busy !== 0 || m_word_count !== 16'd1) begin
      errors++;
      $display("FAIL msb_end: got busy %0b wc %0d, required 0 1", m_busy, m_word_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w [3];
    int k, n, p0;
    bit fire, saw_stall;
    w[0] = 32'h03020100; w[1] = 32'h07060504; w[2] = 32'h0B0A0908;
    do_reset();
    k = 0; n = 0; saw_stall = 0; p0 = pops;
    in_valid = 1; in_data = w[0];
    while ((pops - p0) < 12 && n < 40) begin
      fire = in_valid && in_ready;
      if (in_valid && !in_ready) saw_stall = 1;
      cycle();
      n++;
      if (fire) begin
        k++;
        if (k == 3) in_valid = 0;
        else in_data = w[k];
      end
    end
    checks++;
    if (n !== 13) begin
      errors++;
      $display("FAIL b2b_cycles: got %0d cycles for 12 bytes, required 13", n);
    end
    checks++;
    if (saw_stall !== 1) begin
      errors++;
      $display("FAIL b2b_stall: got in_ready stall seen %0b, required 1", saw_stall);
    end
    checks++;
    if (word_count !== 16'd3 || busy !== 0) begin
      errors++;
      $display("FAIL b2b_end: got wc %0d busy %0b, required 3 0", word_count, busy);
    end
  endtask

  task automatic test_backpressure();
    int n;
    bit fire;
    do_reset();
    in_valid = 1; in_data = 32'h11223344;
    cycle();
    in_valid = 0;
    cycle();
    out_ready = 0;
    in_valid = 1; in_data = 32'h55667788;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (out_valid !== 1 || out_data !== 8'h33) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got v%0b %02h, required v1 33", k, out_valid, out_data);
      end
      if (k >= 1) begin
        checks++;
        if (in_ready !== 0) begin
          errors++;
          $display("FAIL bp_in_ready[%0d]: got %0b, required 0", k, in_ready);
        end
      end
      cycle();
      if (k == 0) in_data = 32'h99AABBCC;
    end
    out_ready = 1;
    n = 0;
    while ((in_valid || busy) && n < 40) begin
      fire = in_valid && in_ready;
      cycle();
      n++;
      if (fire) in_valid = 0;
    end
    checks++;
    if (word_count !== 16'd3 || q.size() !== 0 || busy !== 0) begin
      errors++;
      $display("FAIL bp_end: got wc %0d queued %0d busy %0b, required 3 0 0", word_count, q.size(), busy);
    end
  endtask

  task automatic test_reset_midword();
    int n;
    in_valid = 1; in_data = 32'h12345678;
    cycle();
    in_valid = 0;
    cycle();
    cycle();
    #2;
    rst_n = 0;
    #1;
    checks++;
    if (out_valid !== 0 || busy !== 0 || word_count !== 16'd0 || in_ready !== 1) begin
      errors++;
      $display("FAIL async_reset: got v%0b busy%0b wc%0d r%0b, required v0 busy0 wc0 r1",
               out_valid, busy, word_count, in_ready);
    end
    q.delete();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    in_valid = 1; in_data = 32'hCAFEF00D;
    cycle();
    in_valid = 0;
    n = 0;
    while (busy && n < 20) begin
      cycle();
      n++;
    end
    checks++;
    if (word_count !== 16'd1 || q.size() !== 0 || n !== 4) begin
      errors++;
      $display("FAIL post_reset_word: got wc %0d queued %0d cycles %0d, required 1 0 4", word_count, q.size(), n);
    end
  endtask

  task automatic test_wrap();
    int acc, n;
    bit fire;
    do_reset();
    acc = 0; n = 0;
    c_in_valid = 1; c_in_data = 32'hDEAD0000;
    while ((c_in_valid || c_busy) && n < 200) begin
      fire = c_in_valid && c_in_ready;
      cycle();
      n++;
      if (fire) begin
        acc++;
        c_in_data = c_in_data + 32'd1;
        if (acc == 17) c_in_valid = 0;
      end
    end
    checks++;
    if (acc !== 17 || c_word_count !== 4'd1) begin
      errors++;
      $display("FAIL wrap: got accepted %0d wc %0d, required 17 1", acc, c_word_count);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    pops = 0;
    rst_n = 1;
    idle_inputs();
    #2;
    rst_n = 0;
    #10;
    test_reset();
    test_single();
    test_msb();
    test_back_to_back();
    test_backpressure();
    test_reset_midword();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
